// File: rtl/fifo_wr_ctrl_if.sv
// ============================================================================
// Module   : fifo_wr_ctrl_if
// Brief    : Producer stream and FIFO write-port bundle for fifo_wr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wr_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             s_valid;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic             s_ready;
   logic             fifo_full;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;

   // master is the environment side: the producer plus the FIFO's full flag
   modport master (
      output s_valid, s_data, s_last, fifo_full,
      input  s_ready, wr_en, wr_data
   );

   modport slave (
      input  s_valid, s_data, s_last, fifo_full,
      output s_ready, wr_en, wr_data
   );
endinterface

`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
// ============================================================================
// Module   : fifo_wr_ctrl
// Brief    : Async-FIFO write-side ingress controller with 2-entry skid buffer
//            and mid-packet stall timeout. Macro FIFO_WR_CTRL_STATS_EN builds
//            the word/drop statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  wire logic             wr_clk,
   input  wire logic             rstn,
   fifo_wr_ctrl_if.slave         bus,
   output logic                  pkt_drop,
   output logic                  busy,
   output logic [CNT_W-1:0]      word_cnt,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam logic [15:0] C_STALL_MAX = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_data [2];
   logic             r_last [2];
   logic             r_head;
   logic [1:0]       r_count;
   logic [15:0]      r_stall;
   logic [15:0]      w_stall_nxt;
   logic [WIDTH-1:0] r_hold;
   logic             r_pkt_drop;
   logic             w_drop_enter;

   logic             w_head_valid;
   logic [WIDTH-1:0] w_head_data;
   logic             w_head_last;
   logic             w_ready;
   logic             w_accept;
   logic             w_wr_en;
   logic             w_drop_pop;
   logic             w_pop;
   logic             w_push;
   logic             w_tail;

   assign w_head_valid = (r_count != 2'd0);
   assign w_head_data  = r_data[r_head];
   assign w_head_last  = r_last[r_head];
   assign w_ready      = (r_state == ST_DROP) || (r_count != 2'd2);
   assign w_accept     = bus.s_valid && w_ready;
   assign w_wr_en      = w_head_valid && !bus.fifo_full && (r_state != ST_DROP);
   assign w_drop_pop   = (r_state == ST_DROP) && w_head_valid;
   assign w_pop        = w_wr_en || w_drop_pop;
   // in DROP with an empty buffer, accepted beats are discarded, not stored
   assign w_push       = w_accept && !((r_state == ST_DROP) && !w_head_valid);
   assign w_tail       = r_head ^ r_count[0];

   always_comb begin
      w_state_nxt  = r_state;
      w_stall_nxt  = r_stall;
      w_drop_enter = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_stall_nxt = 16'd0;
            if (w_wr_en && !w_head_last) begin
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_wr_en) begin
               w_stall_nxt = 16'd0;
               if (w_head_last) begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_head_valid && bus.fifo_full) begin
               if (r_stall == C_STALL_MAX) begin
                  w_state_nxt  = ST_DROP;
                  w_stall_nxt  = 16'd0;
                  w_drop_enter = 1'b1;
               end else begin
                  w_stall_nxt = r_stall + 16'd1;
               end
            end
         end
         ST_DROP: begin
            w_stall_nxt = 16'd0;
            if (w_drop_pop) begin
               if (w_head_last) begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_accept && bus.s_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_stall_nxt = 16'd0;
         end
      endcase
   end

   always_ff @(posedge wr_clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_stall    <= 16'd0;
         r_pkt_drop <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_stall    <= w_stall_nxt;
         r_pkt_drop <= w_drop_enter;
      end
   end

   always_ff @(posedge wr_clk or negedge rstn) begin
      if (!rstn) begin
         r_head  <= 1'b0;
         r_count <= 2'd0;
         r_hold  <= '0;
         for (int i = 0; i < 2; i++) begin
            r_data[i] <= '0;
            r_last[i] <= 1'b0;
         end
      end else begin
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         if (w_pop) begin
            r_head <= ~r_head;
         end
         if (w_push) begin
            r_data[w_tail] <= bus.s_data;
            r_last[w_tail] <= bus.s_last;
         end
         if (w_head_valid) begin
            r_hold <= w_head_data;
         end
      end
   end

   assign bus.s_ready = w_ready;
   assign bus.wr_en   = w_wr_en;
   assign bus.wr_data = w_head_valid ? w_head_data : r_hold;
   assign pkt_drop    = r_pkt_drop;
   assign busy        = w_head_valid || (r_state != ST_IDLE);

`ifdef FIFO_WR_CTRL_STATS_EN
   logic [CNT_W-1:0] r_word_cnt;
   logic [CNT_W-1:0] r_drop_cnt;

   always_ff @(posedge wr_clk or negedge rstn) begin
      if (!rstn) begin
         r_word_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_wr_en && (r_word_cnt != '1)) begin
            r_word_cnt <= r_word_cnt + 1'b1;
         end
         if (w_drop_enter && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   assign word_cnt = r_word_cnt;
   assign drop_cnt = r_drop_cnt;
`else
   assign word_cnt = '0;
   assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
// ============================================================================
// Module   : tb_fifo_wr_ctrl
// Brief    : Self-checking bench for fifo_wr_ctrl: directed scenarios plus
//            randomized traffic against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_ctrl;
   localparam int WIDTH = 8;
   localparam int TO    = 8;
   localparam int CNT_W = 16;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic wr_clk = 1'b0;
   logic rstn   = 1'b0;
   always #5 wr_clk = ~wr_clk;

   fifo_wr_ctrl_if #(.WIDTH(WIDTH)) bus ();
   logic             pkt_drop;
   logic             busy;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] drop_cnt;

   fifo_wr_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .wr_clk   (wr_clk),
      .rstn     (rstn),
      .bus      (bus.slave),
      .pkt_drop (pkt_drop),
      .busy     (busy),
      .word_cnt (word_cnt),
      .drop_cnt (drop_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int stat(input int v);
`ifdef FIFO_WR_CTRL_STATS_EN
      return (v > MAXC) ? MAXC : v;
`else
      return 0;
`endif
   endfunction

   // ---------------- behavioural model: queue + packet-level state -------
   logic [WIDTH:0]   mq[$];
   int               ms;      // 0 between packets, 1 mid-packet, 2 discarding
   int               mstall;
   logic [WIDTH-1:0] mhold;
   bit               mpd;
   int               mwords;
   int               mdrops;

   always @(negedge wr_clk) begin
      if (!rstn) begin
         mq.delete(); ms = 0; mstall = 0; mhold = '0; mpd = 0; mwords = 0; mdrops = 0;
         chk("rst_s_ready", bus.s_ready, 1);
         chk("rst_wr_en",   bus.wr_en,   0);
         chk("rst_wr_data", bus.wr_data, 0);
         chk("rst_pkt_drop", pkt_drop,   0);
         chk("rst_busy",     busy,       0);
         chk("rst_word_cnt", word_cnt,   0);
         chk("rst_drop_cnt", drop_cnt,   0);
      end else begin
         int               n;
         bit               e_rdy, e_wen, acc;
         logic [WIDTH-1:0] e_wd;
         logic [WIDTH:0]   beat, h;
         n     = mq.size();
         e_rdy = (ms == 2) || (n < 2);
         e_wen = (n > 0) && !bus.fifo_full && (ms != 2);
         e_wd  = (n > 0) ? mq[0][WIDTH-1:0] : mhold;
         chk("s_ready",  bus.s_ready, e_rdy);
         chk("wr_en",    bus.wr_en,   e_wen);
         chk("wr_data",  bus.wr_data, e_wd);
         chk("pkt_drop", pkt_drop,    mpd);
         chk("busy",     busy,        (n > 0) || (ms != 0));
         chk("word_cnt", word_cnt,    stat(mwords));
         chk("drop_cnt", drop_cnt,    stat(mdrops));
         acc  = bus.s_valid && e_rdy;
         beat = {bus.s_last, bus.s_data};
         if (n > 0) mhold = mq[0][WIDTH-1:0];
         mpd = 0;
         if (ms == 2) begin
            if (n > 0) begin
               h = mq.pop_front();
               if (h[WIDTH]) ms = 0;
               if (acc) mq.push_back(beat);
            end else if (acc && bus.s_last) begin
               ms = 0;
            end
         end else begin
            if (e_wen) begin
               h = mq.pop_front();
               mwords++;
               mstall = 0;
               ms = h[WIDTH] ? 0 : 1;
            end else if (ms == 1 && n > 0 && bus.fifo_full) begin
               if (mstall == TO - 1) begin
                  ms = 2; mstall = 0; mpd = 1; mdrops++;
               end else begin
                  mstall++;
               end
            end
            if (acc) mq.push_back(beat);
         end
      end
   end

   // ---------------- monitors ------------------------------------------
   logic [WIDTH-1:0] wlog[$];
   int               n_pulse = 0;
   bit               mon = 0;
   int               mon_wr = 0;
   int               mon_nr = 0;

   always @(negedge wr_clk) begin
      if (rstn && bus.wr_en) wlog.push_back(bus.wr_data);
      if (rstn && pkt_drop)  n_pulse++;
      if (mon) begin
         if (bus.wr_en)    mon_wr++;
         if (!bus.s_ready) mon_nr++;
      end
   end

   // ---------------- stimulus ------------------------------------------
   logic [WIDTH:0] src[$];
   int             full_mode = 0;
   int             gap_pct   = 0;
   int             burst     = 0;

   task automatic drive();
      bit gap;
      gap = (gap_pct > 0) && ($urandom_range(0, 99) < gap_pct);
      bus.s_valid = (src.size() > 0) && !gap;
      if (src.size() > 0) {bus.s_last, bus.s_data} = src[0];
      case (full_mode)
         0: bus.fifo_full = 1'b0;
         1: bus.fifo_full = 1'b1;
         default: begin
            if (burst > 0) begin
               bus.fifo_full = 1'b1; burst--;
            end else if ($urandom_range(0, 19) == 0) begin
               burst = $urandom_range(1, 14); bus.fifo_full = 1'b1;
            end else begin
               bus.fifo_full = ($urandom_range(0, 9) < 2);
            end
         end
      endcase
   endtask

   task automatic step(input int n);
      bit acc;
      repeat (n) begin
         @(negedge wr_clk);
         acc = rstn && bus.s_valid && bus.s_ready;
         @(posedge wr_clk);
         #1;
         if (acc) void'(src.pop_front());
         drive();
      end
   endtask

   task automatic push_pkt(input logic [WIDTH-1:0] base, input int len);
      for (int i = 0; i < len; i++) src.push_back({(i == len - 1), WIDTH'(base + i)});
   endtask

   initial begin
      bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0; bus.fifo_full = 0;
      repeat (3) @(posedge wr_clk);
      #1 rstn = 1'b1;

      // basic 4-beat stream
      push_pkt(8'h11, 4);
      drive();
      step(8);
      chk("basic_len", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) chk("basic_data", wlog[i], 32'h11 + i);
      chk("basic_word_cnt", word_cnt, stat(4));
      chk("model_words", mwords, 4);

      // backpressure in IDLE: never drops
      wlog.delete();
      full_mode = 1;
      src.push_back({1'b1, 8'h21}); src.push_back({1'b1, 8'h22}); src.push_back({1'b1, 8'h23});
      drive();
      step(100);
      chk("bp_pending", src.size(), 1);
      chk("bp_nowrite", wlog.size(), 0);
      chk("bp_nodrop", n_pulse, 0);
      chk("bp_ready_low", bus.s_ready, 0);
      full_mode = 0;
      drive();
      step(6);
      chk("bp_len", wlog.size(), 3);
      for (int i = 0; i < 3 && i < wlog.size(); i++) chk("bp_data", wlog[i], 32'h21 + i);

      // timeout drop mid-packet
      wlog.delete();
      src.push_back({1'b0, 8'h31}); src.push_back({1'b0, 8'h32});
      drive();
      for (int i = 0; i < 20 && wlog.size() < 2; i++) step(1);
      chk("to_first2", wlog.size(), 2);
      full_mode = 1;
      push_pkt(8'h33, 4);
      push_pkt(8'h41, 2);
      drive();
      step(30);
      chk("to_pulses", n_pulse, 1);
      chk("to_drop_cnt", drop_cnt, stat(1));
      chk("to_word_cnt", word_cnt, stat(9));
      chk("model_drops", mdrops, 1);
      full_mode = 0;
      drive();
      step(6);
      chk("to_len", wlog.size(), 4);
      if (wlog.size() == 4) begin
         chk("to_d0", wlog[0], 32'h31);
         chk("to_d1", wlog[1], 32'h32);
         chk("to_d2", wlog[2], 32'h41);
         chk("to_d3", wlog[3], 32'h42);
      end
      chk("to_word_cnt2", word_cnt, stat(11));

      // simultaneous push/pop keeps a gapless stream
      mon_wr = 0; mon_nr = 0; mon = 1;
      push_pkt(8'h50, 10);
      drive();
      step(12);
      mon = 0;
      chk("pp_writes", mon_wr, 10);
      chk("pp_ready_low", mon_nr, 0);

      // reset in XFER with two entries buffered
      wlog.delete();
      src.push_back({1'b0, 8'h61});
      drive();
      step(3);
      full_mode = 1;
      src.push_back({1'b0, 8'h62}); src.push_back({1'b0, 8'h63}); src.push_back({1'b1, 8'h64});
      drive();
      step(4);
      chk("pre_rst_busy", busy, 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_s_ready", bus.s_ready, 1);
      chk("mid_rst_wr_en", bus.wr_en, 0);
      chk("mid_rst_wr_data", bus.wr_data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_word_cnt", word_cnt, 0);
      src.delete();
      full_mode = 0;
      drive();
      step(2);
      rstn = 1'b1;
      push_pkt(8'h71, 2);
      drive();
      step(6);
      chk("rst_len", wlog.size(), 3);
      if (wlog.size() == 3) begin
         chk("rst_d0", wlog[0], 32'h61);
         chk("rst_d1", wlog[1], 32'h71);
         chk("rst_d2", wlog[2], 32'h72);
      end

      // randomized traffic with full bursts long enough to time out
      full_mode = 2;
      gap_pct   = 25;
      for (int p = 0; p < 300; p++) push_pkt(WIDTH'($urandom), $urandom_range(1, 6));
      drive();
      begin
         int cyc;
         cyc = 0;
         while (src.size() > 0 && cyc < 20000) begin
            step(1);
            cyc++;
         end
         chk("rand_drained", src.size(), 0);
      end
      full_mode = 0;
      gap_pct   = 0;
      drive();
      step(10);
      chk("rand_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
